// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract controller: one operand bit per clock through a
// controlled inverter and a 1-bit full adder, with start/done handshake.
module serial_addsub_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

   stateT            r_state;
   stateT            w_nextState;
   logic [WIDTH-1:0] r_sa;
   logic [WIDTH-1:0] r_sb;
   logic             r_sop;
   logic             r_carry;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_result;
   logic             r_carryOut;
   logic             r_overflow;

   logic             w_bi;
   logic             w_sum;
   logic             w_carryNext;
   logic             w_lastBit;

   assign w_bi        = r_sop ? ~r_sb[0] : r_sb[0];
   assign w_sum       = r_sa[0] ^ w_bi ^ r_carry;
   assign w_carryNext = (r_sa[0] & w_bi) | (r_sa[0] & r_carry) | (w_bi & r_carry);
   assign w_lastBit   = (r_count == CW'(WIDTH - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_nextState = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (w_lastBit) begin
               w_nextState = DONE;
            end
         end
         DONE: begin
            done        = 1'b1;
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // The result register doubles as the sum shift register; it fills from the MSB end.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sa       <= '0;
         r_sb       <= '0;
         r_sop      <= 1'b0;
         r_carry    <= 1'b0;
         r_count    <= '0;
         r_result   <= '0;
         r_carryOut <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_sa       <= a;
                  r_sb       <= b;
                  r_sop      <= op;
                  r_carry    <= op;
                  r_count    <= '0;
                  r_result   <= '0;
                  r_carryOut <= 1'b0;
                  r_overflow <= 1'b0;
               end
            end
            RUN: begin
               r_carry  <= w_carryNext;
               r_result <= {w_sum, r_result[WIDTH-1:1]};
               r_sa     <= r_sa >> 1;
               r_sb     <= r_sb >> 1;
               r_count  <= r_count + CW'(1);
               // On the MSB, r_carry is the carry into the MSB.
               if (w_lastBit) begin
                  r_carryOut <= w_carryNext;
                  r_overflow <= r_carry ^ w_carryNext;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign result    = r_result;
   assign carry_out = r_carryOut;
   assign overflow  = r_overflow;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench for serial_addsub_ctrl: directed cases plus randomized
// operations compared against a plain-arithmetic reference model.
module tb_serial_addsub_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         start;
   logic         op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         carry_out;
   logic         overflow;

   int total = 0;
   int bad = 0;
   int doneSeen = 0;
   int doneExpected = 0;

   serial_addsub_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .op        (op),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .carry_out (carry_out),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   // Counts every done pulse so duplicates or missing pulses show up at the end.
   always @(negedge clk) begin
      if (done === 1'b1) doneSeen++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Reference: plain integer add of a and (b or its two's complement).
   function automatic logic [W+1:0] refModel(input logic iOp, input logic [W-1:0] iA, input logic [W-1:0] iB);
      longint unsigned sum;
      logic [W-1:0]    bEff;
      logic [W-1:0]    res;
      logic            cout;
      logic            ovf;
      bEff = iOp ? ~iB : iB;
      sum  = longint'(iA) + longint'(bEff) + longint'(iOp);
      res  = sum[W-1:0];
      cout = sum[W];
      if (iOp) ovf = (iA[W-1] != iB[W-1]) && (res[W-1] != iA[W-1]);
      else     ovf = (iA[W-1] == iB[W-1]) && (res[W-1] != iA[W-1]);
      return {ovf, cout, res};
   endfunction

   // Runs one full operation starting at a negedge; noise pulses start while busy and in DONE.
   task automatic applyStimulus(input logic iOp, input logic [W-1:0] iA, input logic [W-1:0] iB, input bit noise);
      logic [W+1:0] expected;
      int guard;
      expected = refModel(iOp, iA, iB);
      guard = 0;
      while ((busy !== 1'b0 || done !== 1'b0) && guard < 4 * W) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 4 * W) checkOutput("idleTimeout", 32'(busy | done), 0);
      start = 1'b1;
      op    = iOp;
      a     = iA;
      b     = iB;
      @(negedge clk);
      start = 1'b0;
      op    = 1'($urandom);
      a     = W'($urandom);
      b     = W'($urandom);
      checkOutput("acceptBusy", 32'(busy), 1);
      checkOutput("acceptResultClear", 32'(result), 0);
      checkOutput("acceptFlagsClear", 32'({carry_out, overflow}), 0);
      for (int k = 1; k < W; k++) begin
         if (noise && k == 2) begin
            start = 1'b1;
            op    = 1'b1;
            a     = '1;
            b     = '1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         checkOutput("runBusy", 32'(busy), 1);
         checkOutput("runDone", 32'(done), 0);
      end
      start = 1'b0;
      @(negedge clk);
      checkOutput("doneHigh", 32'(done), 1);
      checkOutput("doneBusyLow", 32'(busy), 0);
      checkOutput("result", 32'(result), 32'(expected[W-1:0]));
      checkOutput("carryOut", 32'(carry_out), 32'(expected[W]));
      checkOutput("overflow", 32'(overflow), 32'(expected[W+1]));
      doneExpected++;
      if (noise) begin
         start = 1'b1;
         op    = 1'b1;
         a     = '1;
         b     = '1;
      end
      @(negedge clk);
      start = 1'b0;
      checkOutput("idleBusy", 32'(busy), 0);
      checkOutput("idleDone", 32'(done), 0);
      checkOutput("resultHeld", 32'(result), 32'(expected[W-1:0]));
      checkOutput("flagsHeld", 32'({carry_out, overflow}), 32'({expected[W], expected[W+1]}));
   endtask

   initial begin
      reset_n = 1'b0;
      start   = 1'b0;
      op      = 1'b0;
      a       = '0;
      b       = '0;
      #2;
      checkOutput("resetBusy", 32'(busy), 0);
      checkOutput("resetDone", 32'(done), 0);
      checkOutput("resetResult", 32'(result), 0);
      checkOutput("resetFlags", 32'({carry_out, overflow}), 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      applyStimulus(1'b0, 8'h3C, 8'h05, 1'b0);
      applyStimulus(1'b1, 8'h05, 8'h07, 1'b0);
      applyStimulus(1'b1, 8'h80, 8'h01, 1'b0);
      applyStimulus(1'b0, 8'h7F, 8'h01, 1'b0);
      applyStimulus(1'b0, 8'hFF, 8'h01, 1'b0);
      applyStimulus(1'b0, 8'h10, 8'h20, 1'b1);

      // Abandon an operation with an asynchronous reset between clock edges.
      start = 1'b1;
      op    = 1'b0;
      a     = 8'hAA;
      b     = 8'h55;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("midResetBusy", 32'(busy), 0);
      checkOutput("midResetDone", 32'(done), 0);
      checkOutput("midResetResult", 32'(result), 0);
      checkOutput("midResetFlags", 32'({carry_out, overflow}), 0);
      repeat (2) @(negedge clk);
      checkOutput("midResetHold", 32'({busy, done}), 0);
      reset_n = 1'b1;
      applyStimulus(1'b1, 8'h00, 8'h01, 1'b0);

      // Back-to-back and randomized operations; each call starts on the first IDLE cycle.
      for (int n = 0; n < 40; n++) begin
         applyStimulus(1'($urandom), W'($urandom), W'($urandom), bit'($urandom_range(0, 1)));
      end
      applyStimulus(1'b1, 8'h00, 8'h00, 1'b1);
      applyStimulus(1'b0, 8'h80, 8'h80, 1'b0);

      @(negedge clk);
      checkOutput("doneCount", 32'(doneSeen), 32'(doneExpected));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
